// File: rtl/acc_pkg.sv
// Shared types and constants for the accumulator job sequencer.
package acc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    SETTLE,
    DRAIN,
    DONE
  } acc_state_e;

  localparam logic ACC_MODE_OVERWRITE = 1'b0;
  localparam logic ACC_MODE_ACCUM     = 1'b1;

  // Accumulator read port latency from acc_rd_en to valid acc_rd_rdata.
  localparam int ACC_RD_LATENCY = 2;

  // Depth of the drain-side skid FIFO; also the read credit limit.
  localparam int ACC_SKID_DEPTH = 4;

endpackage

// File: rtl/acc_skid_fifo.sv
// 4-deep synchronous skid FIFO absorbing accumulator read returns while the
// drain consumer applies backpressure. Overflow is prevented upstream by the
// read credit rule; push/pop are still guarded here.
module acc_skid_fifo
  import acc_pkg::*;
#(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [2:0]       count,
  output logic             empty
);

  localparam int PW = $clog2(ACC_SKID_DEPTH);

  logic [WIDTH-1:0] mem [ACC_SKID_DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == 3'd0);
  assign do_push = push && (count != 3'(ACC_SKID_DEPTH));
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage array; contents are don't-care until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/acc_job_ctrl.sv
// Job sequencer for the SIMD accumulator RAM: N accumulation passes over a
// row window, a settle delay, then a credit-limited backpressured drain.
// Optional macro ACC_JOB_CTRL_STALL_CNT_EN builds the stall cycle counter;
// without it stall_cnt is tied to zero.
module acc_job_ctrl
  import acc_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 10,
  parameter int SETTLE_CYC = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] cfg_base,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [7:0]            cfg_passes,
  output logic                  busy,
  output logic                  done,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  acc_wr_en,
  output logic                  acc_wr_we,
  output logic [ADDR_WIDTH-1:0] acc_wr_addr,
  output logic [DATA_WIDTH-1:0] acc_wr_wdata,
  output logic                  acc_mode,
  output logic                  acc_rd_en,
  output logic [ADDR_WIDTH-1:0] acc_rd_addr,
  input  logic [DATA_WIDTH-1:0] acc_rd_rdata,
  output logic [31:0]           stall_cnt
);

  localparam int SW = $clog2(SETTLE_CYC + 2);

  acc_state_e                state;
  logic [ADDR_WIDTH-1:0]     base_q;
  logic [LEN_WIDTH-1:0]      len_q;
  logic [7:0]                passes_q;
  logic [LEN_WIDTH-1:0]      beat_cnt;
  logic [7:0]                pass_cnt;
  logic [SW-1:0]             settle_cnt;
  logic [LEN_WIDTH-1:0]      rd_cnt;
  logic                      rd_last_q;
  logic [ACC_RD_LATENCY-1:0] pipe_vld;
  logic [ACC_RD_LATENCY-1:0] pipe_last;

  logic                      in_hs;
  logic                      out_hs;
  logic                      last_beat;
  logic                      last_pass;
  logic [2:0]                fifo_count;
  logic                      fifo_empty;
  logic [DATA_WIDTH:0]       fifo_head;
  logic [2:0]                outstanding;
  logic                      rd_issue;

  assign in_hs     = in_valid && in_ready;
  assign out_hs    = out_valid && out_ready;
  assign last_beat = (beat_cnt == len_q - LEN_WIDTH'(1));
  assign last_pass = (pass_cnt == passes_q - 8'd1);

  // Reads already issued but not yet in the FIFO, plus FIFO occupancy,
  // must stay within the FIFO depth so a return can always be stored.
  assign outstanding = 3'(acc_rd_en) + 3'($countones(pipe_vld)) + fifo_count;
  assign rd_issue    = (state == DRAIN) && (rd_cnt != len_q) &&
                       (outstanding < 3'(ACC_SKID_DEPTH));

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? fifo_head[DATA_WIDTH-1:0] : '0;
  assign out_last  = out_valid && fifo_head[DATA_WIDTH];

  acc_skid_fifo #(.WIDTH(DATA_WIDTH + 1)) u_skid (
    .clk   (clk),
    .rst   (rst),
    .push  (pipe_vld[ACC_RD_LATENCY-1]),
    .pop   (out_hs),
    .wdata ({pipe_last[ACC_RD_LATENCY-1], acc_rd_rdata}),
    .rdata (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  // Job FSM with registered write/read port outputs and read-return tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      in_ready     <= 1'b0;
      acc_wr_en    <= 1'b0;
      acc_wr_we    <= 1'b0;
      acc_wr_addr  <= '0;
      acc_wr_wdata <= '0;
      acc_mode     <= ACC_MODE_OVERWRITE;
      acc_rd_en    <= 1'b0;
      acc_rd_addr  <= '0;
      base_q       <= '0;
      len_q        <= '0;
      passes_q     <= '0;
      beat_cnt     <= '0;
      pass_cnt     <= '0;
      settle_cnt   <= '0;
      rd_cnt       <= '0;
      rd_last_q    <= 1'b0;
      pipe_vld     <= '0;
      pipe_last    <= '0;
    end else begin
      done      <= 1'b0;
      acc_wr_en <= 1'b0;
      acc_wr_we <= 1'b0;
      acc_rd_en <= 1'b0;
      rd_last_q <= 1'b0;
      pipe_vld  <= {pipe_vld[ACC_RD_LATENCY-2:0], acc_rd_en};
      pipe_last <= {pipe_last[ACC_RD_LATENCY-2:0], rd_last_q};

      if (in_hs) begin
        acc_wr_en    <= 1'b1;
        acc_wr_we    <= 1'b1;
        acc_wr_addr  <= base_q + beat_cnt[ADDR_WIDTH-1:0];
        acc_wr_wdata <= in_data;
        acc_mode     <= (pass_cnt != 8'd0) ? ACC_MODE_ACCUM : ACC_MODE_OVERWRITE;
      end

      case (state)
        IDLE: begin
          if (start) begin
            base_q   <= cfg_base;
            len_q    <= cfg_len;
            passes_q <= cfg_passes;
            beat_cnt <= '0;
            pass_cnt <= '0;
            rd_cnt   <= '0;
            if (cfg_len == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else if (cfg_passes == 8'd0) begin
              state <= DRAIN;
              busy  <= 1'b1;
            end else begin
              state    <= ACCUM;
              busy     <= 1'b1;
              in_ready <= 1'b1;
            end
          end
        end
        ACCUM: begin
          if (in_hs) begin
            if (last_beat) begin
              beat_cnt <= '0;
              if (last_pass) begin
                state      <= SETTLE;
                in_ready   <= 1'b0;
                settle_cnt <= SW'(SETTLE_CYC);
              end else begin
                pass_cnt <= pass_cnt + 8'd1;
              end
            end else begin
              beat_cnt <= beat_cnt + LEN_WIDTH'(1);
            end
          end
        end
        // First SETTLE cycle carries the final write; SETTLE_CYC idle cycles follow.
        SETTLE: begin
          if (settle_cnt == '0) state <= DRAIN;
          else                  settle_cnt <= settle_cnt - SW'(1);
        end
        DRAIN: begin
          if (rd_issue) begin
            acc_rd_en   <= 1'b1;
            acc_rd_addr <= base_q + rd_cnt[ADDR_WIDTH-1:0];
            rd_last_q   <= (rd_cnt == len_q - LEN_WIDTH'(1));
            rd_cnt      <= rd_cnt + LEN_WIDTH'(1);
          end
          if (out_hs && out_last) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ACC_JOB_CTRL_STALL_CNT_EN
  logic stall_evt;
  assign stall_evt = ((state == ACCUM) && !in_valid) ||
                     ((state == DRAIN) && out_valid && !out_ready);

  // Saturating stall counter, cleared when a new job is accepted.
  always_ff @(posedge clk) begin
    if (rst)                                 stall_cnt <= '0;
    else if ((state == IDLE) && start)       stall_cnt <= '0;
    else if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_acc_job_ctrl.sv
// Directed bench for acc_job_ctrl with a behavioural accumulator RAM
// (per-lane 16-bit accumulate, 2-cycle read latency).
module tb_acc_job_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  cfg_base;
  logic [9:0]  cfg_len;
  logic [7:0]  cfg_passes;
  logic        busy, done;
  logic        in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready, out_last;
  logic [63:0] out_data;
  logic        acc_wr_en, acc_wr_we, acc_mode, acc_rd_en;
  logic [8:0]  acc_wr_addr, acc_rd_addr;
  logic [63:0] acc_wr_wdata, acc_rd_rdata;
  logic [31:0] stall_cnt;

  always #5 clk = ~clk;

  acc_job_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .cfg_base(cfg_base), .cfg_len(cfg_len),
    .cfg_passes(cfg_passes), .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .acc_wr_en(acc_wr_en), .acc_wr_we(acc_wr_we), .acc_wr_addr(acc_wr_addr),
    .acc_wr_wdata(acc_wr_wdata), .acc_mode(acc_mode), .acc_rd_en(acc_rd_en),
    .acc_rd_addr(acc_rd_addr), .acc_rd_rdata(acc_rd_rdata), .stall_cnt(stall_cnt)
  );

  // Accumulator RAM model
  logic [63:0] ram [512];
  logic [63:0] rd_d1;

  function automatic logic [63:0] lane_add(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r;
    for (int i = 0; i < 4; i++) r[16*i +: 16] = a[16*i +: 16] + b[16*i +: 16];
    return r;
  endfunction

  always @(posedge clk) begin
    if (acc_wr_en && acc_wr_we)
      ram[acc_wr_addr] <= acc_mode ? lane_add(ram[acc_wr_addr], acc_wr_wdata) : acc_wr_wdata;
    rd_d1        <= ram[acc_rd_addr];
    acc_rd_rdata <= rd_d1;
  end

  // Observation logs
  logic [8:0]  wr_addr_q[$];
  logic [63:0] wr_data_q[$];
  logic        wr_mode_q[$];
  logic [8:0]  rd_addr_q[$];
  logic [63:0] out_data_q[$];
  logic        out_last_q[$];
  int done_cnt, overlap_cnt, issued, popped, max_out;
  int n_chk, n_pass;
  logic job_to;
  logic [63:0] beats [16];

  always @(negedge clk) begin
    if (acc_wr_en) begin
      wr_addr_q.push_back(acc_wr_addr);
      wr_data_q.push_back(acc_wr_wdata);
      wr_mode_q.push_back(acc_mode);
    end
    if (acc_rd_en) begin
      rd_addr_q.push_back(acc_rd_addr);
      issued++;
    end
    if (acc_wr_en && acc_rd_en) overlap_cnt++;
    if (issued - popped > max_out) max_out = issued - popped;
    if (out_valid && out_ready) begin
      out_data_q.push_back(out_data);
      out_last_q.push_back(out_last);
      popped++;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_mode_q.delete();
    rd_addr_q.delete(); out_data_q.delete(); out_last_q.delete();
    done_cnt = 0; max_out = 0;
  endtask

  task automatic run_job(input logic [8:0] b, input logic [9:0] l, input logic [7:0] p,
                         input int rmode);
    int idx, cyc, total;
    logic hs;
    clear_logs();
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b1; cfg_base = b; cfg_len = l; cfg_passes = p;
    @(posedge clk); #1;
    start = 1'b0;
    total = int'(l) * int'(p);
    idx = 0; cyc = 0;
    while (idx < total && cyc < 1000) begin
      in_valid = 1'b1;
      in_data  = beats[idx];
      @(negedge clk);
      hs = in_ready;
      @(posedge clk); #1;
      if (hs) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    cyc = 0;
    while (done_cnt == 0 && cyc < 2000) begin
      out_ready = (rmode == 0) ? 1'b1 : (cyc % 4 == 0);
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b1;
    job_to = (done_cnt == 0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    done_cnt = 0; overlap_cnt = 0; issued = 0; popped = 0; max_out = 0;
    for (int i = 0; i < 512; i++) ram[i] = 64'h0;
    rst = 1'b1; start = 1'b0; cfg_base = '0; cfg_len = '0; cfg_passes = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wr_en", acc_wr_en, 0);
    chk("rst_rd_en", acc_rd_en, 0);
    chk("rst_stall_cnt", stall_cnt, 0);

    // Job 1: single overwrite pass, drain 1..4
    for (int i = 0; i < 4; i++) beats[i] = 64'(i + 1);
    run_job(9'h010, 10'd4, 8'd1, 0);
    chk("t1_timeout", job_to, 0);
    chk("t1_n_writes", wr_addr_q.size(), 4);
    for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
      chk("t1_wr_addr", wr_addr_q[i], 64'(9'h010 + i));
      chk("t1_wr_data", wr_data_q[i], 64'(i + 1));
      chk("t1_wr_mode", wr_mode_q[i], 0);
    end
    chk("t1_n_out", out_data_q.size(), 4);
    for (int i = 0; i < 4 && i < out_data_q.size(); i++) begin
      chk("t1_out_data", out_data_q[i], 64'(i + 1));
      chk("t1_out_last", out_last_q[i], (i == 3) ? 64'd1 : 64'd0);
    end
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_busy_after", busy, 0);

    // Job 2: three passes, per-lane sums
    for (int i = 0; i < 6; i++) beats[i] = 64'h0001_0002_0003_0004;
    run_job(9'h020, 10'd2, 8'd3, 0);
    chk("t2_timeout", job_to, 0);
    chk("t2_n_writes", wr_addr_q.size(), 6);
    for (int i = 0; i < 6 && i < wr_mode_q.size(); i++)
      chk("t2_wr_mode", wr_mode_q[i], (i < 2) ? 64'd0 : 64'd1);
    chk("t2_n_out", out_data_q.size(), 2);
    for (int i = 0; i < 2 && i < out_data_q.size(); i++)
      chk("t2_out_data", out_data_q[i], 64'h0003_0006_0009_000C);
    chk("t2_done_cnt", done_cnt, 1);

    // Job 3: lane wrap without carry into lane 1
    beats[0] = 64'h0000_0000_0000_FFFF;
    beats[1] = 64'h0000_0000_0000_0002;
    run_job(9'h030, 10'd1, 8'd2, 0);
    chk("t3_timeout", job_to, 0);
    chk("t3_n_out", out_data_q.size(), 1);
    if (out_data_q.size() > 0) chk("t3_out_data", out_data_q[0], 64'h0000_0000_0000_0001);

    // Job 4: address wrap-around
    for (int i = 0; i < 4; i++) beats[i] = 64'h00A0 + 64'(i);
    run_job(9'h1FE, 10'd4, 8'd1, 0);
    chk("t4_timeout", job_to, 0);
    chk("t4_n_writes", wr_addr_q.size(), 4);
    chk("t4_n_reads", rd_addr_q.size(), 4);
    if (wr_addr_q.size() == 4 && rd_addr_q.size() == 4) begin
      chk("t4_wr_addr0", wr_addr_q[0], 9'h1FE);
      chk("t4_wr_addr1", wr_addr_q[1], 9'h1FF);
      chk("t4_wr_addr2", wr_addr_q[2], 9'h000);
      chk("t4_wr_addr3", wr_addr_q[3], 9'h001);
      chk("t4_rd_addr0", rd_addr_q[0], 9'h1FE);
      chk("t4_rd_addr1", rd_addr_q[1], 9'h1FF);
      chk("t4_rd_addr2", rd_addr_q[2], 9'h000);
      chk("t4_rd_addr3", rd_addr_q[3], 9'h001);
    end
    for (int i = 0; i < 4 && i < out_data_q.size(); i++)
      chk("t4_out_data", out_data_q[i], 64'h00A0 + 64'(i));

    // Job 5: backpressured drain, 1 cycle ready / 3 cycles stalled
    for (int i = 0; i < 8; i++) beats[i] = 64'h0100 + 64'(i);
    run_job(9'h040, 10'd8, 8'd1, 1);
    chk("t5_timeout", job_to, 0);
    chk("t5_n_out", out_data_q.size(), 8);
    for (int i = 0; i < 8 && i < out_data_q.size(); i++) begin
      chk("t5_out_data", out_data_q[i], 64'h0100 + 64'(i));
      chk("t5_out_last", out_last_q[i], (i == 7) ? 64'd1 : 64'd0);
    end
    chk("t5_max_inflight_le4", (max_out <= 4), 1);
    chk("t5_done_cnt", done_cnt, 1);
`ifdef ACC_JOB_CTRL_STALL_CNT_EN
    chk("t5_stall_cnt_nonzero", (stall_cnt != 0), 1);
`else
    chk("t5_stall_cnt_zero", stall_cnt, 0);
`endif

    // Job 6: reset mid-drain, then a fresh single-word job
    clear_logs();
    out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; cfg_base = 9'h040; cfg_len = 10'd8; cfg_passes = 8'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    chk("t6_busy_in_drain", busy, 1);
    chk("t6_fifo_holding", out_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    issued = 0; popped = 0;
    @(negedge clk);
    chk("t6_busy_after_rst", busy, 0);
    chk("t6_out_valid_after_rst", out_valid, 0);
    chk("t6_no_done_on_abort", done_cnt, 0);
    beats[0] = 64'h00AB;
    run_job(9'h050, 10'd1, 8'd1, 0);
    chk("t6_timeout", job_to, 0);
    chk("t6_n_out", out_data_q.size(), 1);
    if (out_data_q.size() > 0) begin
      chk("t6_out_data", out_data_q[0], 64'h00AB);
      chk("t6_out_last", out_last_q[0], 1);
    end
    chk("t6_done_cnt", done_cnt, 1);

    // Job 7: zero-length job goes straight to done
    run_job(9'h060, 10'd0, 8'd1, 0);
    chk("t7_timeout", job_to, 0);
    chk("t7_n_writes", wr_addr_q.size(), 0);
    chk("t7_n_out", out_data_q.size(), 0);
    chk("t7_done_cnt", done_cnt, 1);

    chk("wr_rd_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/acc_job_ctrl.md
Name: acc_job_ctrl

Overview:
- Job sequencer in front of the 64-bit SIMD accumulator RAM (write port with overwrite/accumulate `mode`, read port with 2-cycle latency).
- Runs one job over a contiguous row window, in three phases:
  - N accumulation passes of a valid/ready input stream; pass 0 overwrites, later passes accumulate.
  - A settle delay.
  - A drain of the window as a backpressured output stream.
- Sits between the producer datapath (e.g. the Scloud/Frodo matrix multiplier) and the downstream consumer.

Parameters:
- ADDR_WIDTH, 9, accumulator address width.
- DATA_WIDTH, 64, accumulator word width (4 x 16-bit lanes).
- LEN_WIDTH, 10, width of cfg_len (must hold 2^ADDR_WIDTH).
- SETTLE_CYC, 4, idle cycles between the last accumulate write and the first drain read.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle job launch; sampled only in IDLE.
- cfg_base  in  ADDR_WIDTH  first row of the window.
- cfg_len  in  LEN_WIDTH  rows in the window.
- cfg_passes  in  8  number of accumulation passes.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at job end.
- in_valid  in  1  input beat valid.
- in_ready  out  1  controller accepts an input beat.
- in_data  in  DATA_WIDTH  input word.
- out_valid  out  1  drain word valid.
- out_ready  in  1  consumer accepts the drain word.
- out_data  out  DATA_WIDTH  drain word.
- out_last  out  1  marks the final drain word.
- acc_wr_en  out  1  accumulator write port enable.
- acc_wr_we  out  1  accumulator write port write-enable.
- acc_wr_addr  out  ADDR_WIDTH  accumulator write address.
- acc_wr_wdata  out  DATA_WIDTH  accumulator write data.
- acc_mode  out  1  0 = overwrite, 1 = accumulate.
- acc_rd_en  out  1  accumulator read port enable.
- acc_rd_addr  out  ADDR_WIDTH  accumulator read address.
- acc_rd_rdata  in  DATA_WIDTH  accumulator read data, valid 2 cycles after acc_rd_en.
- stall_cnt  out  32  stall counter (see Optional Feature).

Behaviour:
- Clock and reset: one clock `clk`; synchronous active-high reset `rst`.
- Reset values: all outputs 0; state IDLE; counters cleared; skid FIFO emptied. `rst` mid-job aborts immediately; in-flight reads are discarded and no `done` pulse is generated.
- State machine: IDLE -> ACCUM -> SETTLE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - `start` latches the cfg_* inputs.
  - cfg_len == 0: go to DONE.
  - cfg_passes == 0: go to DRAIN (read-only job).
  - Otherwise go to ACCUM.
  - `start` while busy is ignored.
- ACCUM:
  - in_ready = 1.
  - Beat k of pass p (k = 0..len-1, p = 0..passes-1) is written to address (base + k) mod 2^ADDR_WIDTH. Wrap-around is legal.
  - Write outputs are registered: acc_wr_en = acc_wr_we = 1 one cycle after the handshake, with wdata = in_data and acc_mode = (p != 0).
  - Back-to-back beats produce back-to-back writes; the accumulator resolves same-address hazards itself.
  - The handshake of the last beat of the last pass moves the state to SETTLE and drops in_ready in the same cycle it is registered.
- SETTLE: wait SETTLE_CYC cycles after the final write cycle, then go to DRAIN.
- DRAIN:
  - Issue reads at addresses base .. base+len-1 (mod 2^ADDR_WIDTH), one per cycle at most.
  - Credit rule: issue only if (reads in flight + skid FIFO occupancy) < 4.
  - Read data lands 2 cycles later in a 4-entry skid FIFO; out_* is driven from the FIFO head.
  - out_last = 1 on the word from row len-1.
  - Leave for DONE when the out_last word handshakes.
  - No word may be lost or duplicated under arbitrary out_ready patterns.
- DONE: `done` = 1 for exactly 1 cycle, busy = 0, then IDLE. A `start` in the same cycle as `done` is ignored.
- Output order is strictly by row. acc_wr_en and acc_rd_en are never high in the same cycle.

Optional Feature:
- Macro: ACC_JOB_CTRL_STALL_CNT_EN.
- Defined: stall_cnt counts cycles in ACCUM with in_valid = 0 plus cycles in DRAIN with out_valid & !out_ready. It clears on an accepted start and on rst, and saturates at 2^32-1.
- Undefined: stall_cnt is tied to 0 and no counter logic is built.

Decomposition:
- Package acc_pkg holds:
  - acc_state_e (IDLE, ACCUM, SETTLE, DRAIN, DONE).
  - The ACC_MODE_OVERWRITE / ACC_MODE_ACCUM constants.
  - ACC_RD_LATENCY = 2.
  - The skid FIFO depth = 4.
- Sub-module acc_skid_fifo: 4-deep synchronous FIFO with push/pop/count.

Test Plan:
- base = 0x10, len = 4, passes = 1, inputs 1, 2, 3, 4, out_ready = 1 -> four writes with acc_mode = 0 to 0x10..0x13; drain 1, 2, 3, 4; out_last on 4; done pulses once.
- base = 0x20, len = 2, passes = 3, each beat 0x0001_0002_0003_0004 -> drain yields 0x0003_0006_0009_000C twice (per-lane 16-bit sums).
- Lane wrap: passes = 2, words 0xFFFF and 0x0002 to the same row -> drain 0x0001 (no carry into lane 1).
- base = 0x1FE, len = 4 -> writes and reads hit 0x1FE, 0x1FF, 0x000, 0x001 in order.
- len = 8 with out_ready toggled 1 cycle on / 3 off -> all 8 words in order, in-flight + FIFO never > 4, out_last only on the 8th; stall_cnt > 0 when the macro is defined.
- Assert rst mid-DRAIN, then start a new job with len = 1, passes = 1, input 0xAB -> no stale words appear; drain 0xAB; exactly one done pulse.
